// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage; stalls the pipeline through busy_wait.
// Define FAST_MUL_EN to compute multiplies with a single-cycle product instead of the shift-add loop.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      in_alu_op,
  input  logic [XLEN-1:0] in_data1,
  input  logic [XLEN-1:0] in_data2,
  input  logic            in_valid,
  output logic [XLEN-1:0] out_result,
  output logic            out_done,
  output logic            busy_wait
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [5:0]          cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     b_q, b_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic [2:0]          fn;
  logic                start, s1, s2, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     quo, rem;

  assign fn    = in_alu_op[2:0];
  assign start = in_valid & (in_alu_op[4:3] == 2'b01) & (state_q == IDLE) & ~reset;
  assign s1    = (fn == 3'b001) | (fn == 3'b010) | (fn == 3'b100) | (fn == 3'b110);
  assign s2    = (fn == 3'b001) | (fn == 3'b100) | (fn == 3'b110);
  assign a_neg = s1 & in_data1[XLEN-1];
  assign b_neg = s2 & in_data2[XLEN-1];
  assign a_mag = a_neg ? -in_data1 : in_data1;
  assign b_mag = b_neg ? -in_data2 : in_data2;
  assign div0  = fn[2] & (in_data2 == '0);
  assign ovf   = fn[2] & ~fn[0] & (in_data1 == {1'b1, {(XLEN-1){1'b0}}}) & (in_data2 == '1);

  assign busy_wait  = start | (state_q == RUN) | (state_q == FIX);
  assign out_done   = (state_q == DONE);
  assign out_result = result_q;

  // acc holds {partial product / remainder, multiplier / quotient}
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, b_q};

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] wide_a, wide_b;
  assign wide_a = {{XLEN{neg_q & acc_q[XLEN-1]}}, acc_q[XLEN-1:0]};
  assign wide_b = {{XLEN{rneg_q & b_q[XLEN-1]}}, b_q};
  assign prod   = $signed(wide_a) * $signed(wide_b);
`else
  assign prod   = neg_q ? -acc_q : acc_q;
`endif
  assign quo = neg_q  ? -acc_q[XLEN-1:0]      : acc_q[XLEN-1:0];
  assign rem = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d  = fn;
          cnt_d = '0;
          if (div0) begin
            // Quotient all ones, remainder is the raw dividend.
            acc_d   = {in_data1, {XLEN{1'b1}}};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
          end else if (ovf) begin
            acc_d   = {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}};
            neg_d   = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
`ifdef FAST_MUL_EN
          end else if (!fn[2]) begin
            // Raw operands and their signedness feed the single-cycle product.
            acc_d   = {{XLEN{1'b0}}, in_data1};
            b_d     = in_data2;
            neg_d   = s1;
            rneg_d  = s2;
            state_d = FIX;
`endif
          end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag};
            b_d     = b_mag;
            neg_d   = a_neg ^ b_neg;
            rneg_d  = a_neg;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (op_q[2]) begin
          if (!div_diff[XLEN]) acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else                 acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        if (op_q[2])               result_d = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00) result_d = prod[XLEN-1:0];
        else                       result_d = prod[2*XLEN-1:XLEN];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: results, stall lengths, reset abort, bubbles.
module tb_ex_muldiv_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  in_alu_op;
  logic [31:0] in_data1;
  logic [31:0] in_data2;
  logic        in_valid;
  logic [31:0] out_result;
  logic        out_done;
  logic        busy_wait;

  int checks = 0;
  int errors = 0;

`ifdef FAST_MUL_EN
  localparam int MUL_BUSY = 2;
`else
  localparam int MUL_BUSY = 34;
`endif
  localparam int DIV_BUSY = 34;
  localparam int SPC_BUSY = 2;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_alu_op(in_alu_op), .in_data1(in_data1),
    .in_data2(in_data2), .in_valid(in_valid), .out_result(out_result),
    .out_done(out_done), .busy_wait(busy_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one M op, hold it while stalled, then leave one bubble cycle.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res, input int exp_busy);
    int n;
    n = 0;
    in_valid = 1'b1; in_alu_op = op; in_data1 = a; in_data2 = b;
    #1;
    while (busy_wait === 1'b1 && n < 200) begin
      n++;
      @(posedge clk); #1;
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_busy));
    check({tag, "_done"}, {31'b0, out_done}, 32'd1);
    check({tag, "_result"}, out_result, exp_res);
    $display("op=%b a=%h b=%h result=%h busy_cycles=%0d", op, a, b, out_result, n);
    @(posedge clk); #1;
    in_valid = 1'b0; in_alu_op = 5'b0;
    #1;
    check({tag, "_done_once"}, {31'b0, out_done}, 32'd0);
    check({tag, "_no_reissue"}, {31'b0, busy_wait}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_bubble_idle"}, {30'b0, out_done, busy_wait}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_alu_op = 5'b0; in_data1 = '0; in_data2 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'b0, busy_wait}, 32'd0);
    check("reset_done", {31'b0, out_done}, 32'd0);
    check("reset_result", out_result, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_7_m3", 5'b01000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_BUSY);

    // Abort a divide mid-RUN with asynchronous reset.
    in_valid = 1'b1; in_alu_op = 5'b01100; in_data1 = 32'd1000; in_data2 = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    check("midrun_busy", {31'b0, busy_wait}, 32'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'b0, busy_wait}, 32'd0);
    check("abort_done", {31'b0, out_done}, 32'd0);
    check("abort_result", out_result, 32'd0);
    $display("reset asserted during DIV run: busy=%b done=%b result=%h", busy_wait, out_done, out_result);
    in_valid = 1'b0; in_alu_op = 5'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("mul_3_4", 5'b01000, 32'd3, 32'd4, 32'd12, MUL_BUSY);
    run_op("mulh", 5'b01001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, MUL_BUSY);
    run_op("mulhsu", 5'b01010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, MUL_BUSY);
    run_op("mulhu", 5'b01011, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, MUL_BUSY);
    run_op("div_m7_2", 5'b01100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_BUSY);
    run_op("rem_m7_2", 5'b01110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, DIV_BUSY);
    run_op("div_7_m2", 5'b01100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_BUSY);
    run_op("rem_7_m2", 5'b01110, 32'd7, 32'hFFFF_FFFE, 32'd1, DIV_BUSY);
    run_op("div_by0", 5'b01100, 32'd5, 32'd0, 32'hFFFF_FFFF, SPC_BUSY);
    run_op("remu_by0", 5'b01111, 32'd5, 32'd0, 32'd5, SPC_BUSY);
    run_op("div_ovf", 5'b01100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, SPC_BUSY);
    run_op("rem_ovf", 5'b01110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, SPC_BUSY);
    run_op("divu_100_7", 5'b01101, 32'd100, 32'd7, 32'd14, DIV_BUSY);
    run_op("mul_5_6", 5'b01000, 32'd5, 32'd6, 32'd30, MUL_BUSY);
    run_op("remu_100_7", 5'b01111, 32'd100, 32'd7, 32'd2, DIV_BUSY);

    // A valid non-M op must be ignored entirely.
    in_valid = 1'b1; in_alu_op = 5'b00010; in_data1 = 32'd9; in_data2 = 32'd9;
    #1;
    check("nonm_busy", {31'b0, busy_wait}, 32'd0);
    repeat (3) begin @(posedge clk); #1; end
    check("nonm_idle", {30'b0, out_done, busy_wait}, 32'd0);
    $display("non-M op 00010 valid: busy=%b done=%b", busy_wait, out_done);
    in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
